conv2d_mc: RTL and testbench

Multi-channel 2D convolution engine, the parametrised successor of the single-channel conv block.
- Accumulates signed-kernel x unsigned-pixel products across up to CHANNELS input planes.
- Adds zero padding, optional ReLU, an arithmetic right-shift requantiser and signed saturation.
- Sits behind the same byte-packed input write port and word output read port; a host loads the planes, pulses start, waits on done and reads results.

---
 rtl/conv2d_mc.sv | 260 ++++++++++++++++++++++++++
 tb/tb_conv2d_mc.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_mc.sv
// Multi-channel 2D convolution engine: signed int8 kernel over unsigned 8-bit planes,
// with zero padding, optional ReLU, arithmetic-shift requantiser and signed saturation.
module conv2d_mc #(
  parameter int DSIZE    = 1024,
  parameter int OSIZE    = 256,
  parameter int KSIZE    = 3,
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 24,
  parameter int OUT_W    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  input  logic [7:0]                          data_width,
  input  logic [7:0]                          data_height,
  input  logic [7:0]                          result_width,
  input  logic [7:0]                          result_height,
  input  logic [3:0]                          stride_x,
  input  logic [3:0]                          stride_y,
  input  logic [3:0]                          kernel_width,
  input  logic [3:0]                          kernel_height,
  input  logic [3:0]                          num_ch,
  input  logic [1:0]                          pad,
  input  logic                                relu_en,
  input  logic [4:0]                          shift,
  input  logic [8*KSIZE*KSIZE*CHANNELS-1:0]   kernel,
  input  logic [$clog2(DSIZE):0]              mi_addr,
  input  logic [31:0]                         mi_data,
  input  logic                                mi_wr,
  input  logic [$clog2(OSIZE):0]              mo_addr,
  output logic [31:0]                         mo_data
);

  localparam int DA_W = $clog2(DSIZE) + 1;
  localparam int OA_W = $clog2(OSIZE) + 1;
  localparam int KB_W = 8 * KSIZE * KSIZE * CHANNELS;
  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_W - 1));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  function automatic logic [31:0] sat_to_out(input logic signed [ACC_W-1:0] v);
    logic signed [31:0] v32;
    v32 = {{(32 - ACC_W){v[ACC_W-1]}}, v};
    if (v32 > SAT_MAX) begin
      sat_to_out = SAT_MAX;
    end else if (v32 < SAT_MIN) begin
      sat_to_out = SAT_MIN;
    end else begin
      sat_to_out = v32;
    end
  endfunction

  state_t r_state, w_state_nxt;
  logic   r_busy, r_done, w_busy_nxt, w_done_nxt;

  logic [7:0]      r_dw, r_dh, r_rw, r_rh;
  logic [3:0]      r_sx, r_sy, r_kw, r_kh, r_nch;
  logic [1:0]      r_pad;
  logic            r_relu;
  logic [4:0]      r_shift;
  logic [KB_W-1:0] r_kernel;

  logic [7:0]              r_ox, r_oy;
  logic [3:0]              r_c, r_ky, r_kx;
  logic signed [ACC_W-1:0] r_acc;
  logic [31:0]             r_mo_data;

  logic [7:0]  r_imem [0:DSIZE-1];
  logic [31:0] r_omem [0:OSIZE-1];

  logic [3:0]  w_kw_cl, w_kh_cl, w_nch_cl, w_sx_cl, w_sy_cl;
  logic        w_kx_end, w_ky_end, w_c_end, w_ox_end, w_oy_end;
  logic        w_last_tap, w_last_pix, w_empty;
  logic [15:0] w_ixu, w_iyu;
  logic signed [15:0] w_ix, w_iy;
  logic        w_valid;
  logic [31:0] w_paddr, w_widx;
  logic [7:0]  w_pix;
  logic signed [7:0]  w_wt;
  logic signed [16:0] w_prod;
  logic signed [ACC_W-1:0] w_shifted, w_relu_v;
  logic [31:0] w_res;
  logic [15:0] w_oaddr;

  assign busy    = r_busy;
  assign done    = r_done;
  assign mo_data = r_mo_data;

  assign w_kw_cl  = (kernel_width  > 4'(KSIZE))    ? 4'(KSIZE)    : kernel_width;
  assign w_kh_cl  = (kernel_height > 4'(KSIZE))    ? 4'(KSIZE)    : kernel_height;
  assign w_nch_cl = (num_ch        > 4'(CHANNELS)) ? 4'(CHANNELS) : num_ch;
  assign w_sx_cl  = (stride_x == 4'd0) ? 4'd1 : stride_x;
  assign w_sy_cl  = (stride_y == 4'd0) ? 4'd1 : stride_y;

  assign w_kx_end   = ({1'b0, r_kx} + 5'd1) >= {1'b0, r_kw};
  assign w_ky_end   = ({1'b0, r_ky} + 5'd1) >= {1'b0, r_kh};
  assign w_c_end    = ({1'b0, r_c}  + 5'd1) >= {1'b0, r_nch};
  assign w_ox_end   = ({1'b0, r_ox} + 9'd1) >= {1'b0, r_rw};
  assign w_oy_end   = ({1'b0, r_oy} + 9'd1) >= {1'b0, r_rh};
  assign w_last_tap = w_kx_end && w_ky_end && w_c_end;
  assign w_last_pix = w_ox_end && w_oy_end;
  assign w_empty    = (r_nch == 4'd0) || (r_rw == 8'd0) || (r_rh == 8'd0);

  // Tap coordinates can go negative once padding is subtracted, hence signed compares
  assign w_ixu   = 16'(r_ox) * 16'(r_sx) + 16'(r_kx);
  assign w_iyu   = 16'(r_oy) * 16'(r_sy) + 16'(r_ky);
  assign w_ix    = $signed(w_ixu) - $signed({14'd0, r_pad});
  assign w_iy    = $signed(w_iyu) - $signed({14'd0, r_pad});
  assign w_valid = (w_ix >= 16'sd0) && (w_ix < $signed({8'd0, r_dw})) &&
                   (w_iy >= 16'sd0) && (w_iy < $signed({8'd0, r_dh}));
  assign w_paddr = 32'(r_c) * 32'(r_dw) * 32'(r_dh) + 32'(w_iy[7:0]) * 32'(r_dw) + 32'(w_ix[7:0]);
  assign w_pix   = (w_valid && (w_paddr < 32'(DSIZE))) ? r_imem[w_paddr[DA_W-2:0]] : 8'd0;
  assign w_widx  = 32'(r_c) * 32'(KSIZE * KSIZE) + 32'(r_ky) * 32'(KSIZE) + 32'(r_kx);
  assign w_wt    = $signed(r_kernel[8*w_widx +: 8]);
  assign w_prod  = $signed({9'd0, w_pix}) * $signed({{9{w_wt[7]}}, w_wt});

  assign w_shifted = r_acc >>> r_shift;
  assign w_relu_v  = (r_relu && w_shifted[ACC_W-1]) ? '0 : w_shifted;
  assign w_res     = sat_to_out(w_relu_v);
  assign w_oaddr   = 16'(r_oy) * 16'(r_rw) + 16'(r_ox);

  // State register with registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)      w_state_nxt = S_SETUP; else w_state_nxt = S_IDLE;
      S_SETUP: if (w_empty)    w_state_nxt = S_FIN;   else w_state_nxt = S_MAC;
      S_MAC:   if (w_last_tap) w_state_nxt = S_WRITE; else w_state_nxt = S_MAC;
      S_WRITE: if (w_last_pix) w_state_nxt = S_FIN;   else w_state_nxt = S_MAC;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of busy/done
  always_comb begin
    w_busy_nxt = r_busy;
    w_done_nxt = r_done;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_busy_nxt = 1'b1;
          w_done_nxt = 1'b0;
        end else begin
          w_busy_nxt = r_busy;
          w_done_nxt = r_done;
        end
      end
      S_FIN: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = r_busy;
        w_done_nxt = r_done;
      end
    endcase
  end

  // Configuration latch, tap/pixel counters and accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dw <= 8'd0; r_dh <= 8'd0; r_rw <= 8'd0; r_rh <= 8'd0;
      r_sx <= 4'd1; r_sy <= 4'd1; r_kw <= 4'd0; r_kh <= 4'd0; r_nch <= 4'd0;
      r_pad <= 2'd0; r_relu <= 1'b0; r_shift <= 5'd0; r_kernel <= '0;
      r_ox <= 8'd0; r_oy <= 8'd0; r_c <= 4'd0; r_ky <= 4'd0; r_kx <= 4'd0;
      r_acc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dw <= data_width;    r_dh <= data_height;
            r_rw <= result_width;  r_rh <= result_height;
            r_sx <= w_sx_cl; r_sy <= w_sy_cl; r_kw <= w_kw_cl; r_kh <= w_kh_cl;
            r_nch <= w_nch_cl; r_pad <= pad; r_relu <= relu_en; r_shift <= shift;
            r_kernel <= kernel;
          end
        end
        S_SETUP: begin
          r_acc <= '0;
          r_ox <= 8'd0; r_oy <= 8'd0; r_c <= 4'd0; r_ky <= 4'd0; r_kx <= 4'd0;
        end
        S_MAC: begin
          r_acc <= r_acc + {{(ACC_W-17){w_prod[16]}}, w_prod};
          if (!w_kx_end) begin
            r_kx <= r_kx + 4'd1;
          end else begin
            r_kx <= 4'd0;
            if (!w_ky_end) begin
              r_ky <= r_ky + 4'd1;
            end else begin
              r_ky <= 4'd0;
              r_c  <= w_c_end ? 4'd0 : r_c + 4'd1;
            end
          end
        end
        S_WRITE: begin
          r_acc <= '0;
          if (!w_ox_end) begin
            r_ox <= r_ox + 8'd1;
          end else begin
            r_ox <= 8'd0;
            r_oy <= r_oy + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Host writes into the input memory, only while idle
  always_ff @(posedge clk) begin
    if (mi_wr && !r_busy && (mi_addr < DA_W'(DSIZE))) begin
      for (int i = 0; i < 4; i++) begin
        r_imem[{mi_addr[DA_W-2:2], i[1:0]}] <= mi_data[8*i +: 8];
      end
    end
  end

  // Result store; gated by rst_n so a reset in WRITE leaves memory untouched
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == S_WRITE) && (w_oaddr < 16'(OSIZE))) begin
      r_omem[w_oaddr[OA_W-2:0]] <= w_res;
    end
  end

  // Registered output read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mo_data <= 32'd0;
    end else if (mo_addr < OA_W'(OSIZE)) begin
      r_mo_data <= r_omem[mo_addr[OA_W-2:0]];
    end else begin
      r_mo_data <= 32'd0;
    end
  end

endmodule

// File: tb/tb_conv2d_mc.sv
// Directed self-checking bench for conv2d_mc: one task per scenario, expected
// values computed by hand from the convolution definition.
module tb_conv2d_mc;

  logic         clk = 1'b0;
  logic         rst_n, start, busy, done;
  logic [7:0]   dw, dh, rw, rh;
  logic [3:0]   sx, sy, kw, kh, nch;
  logic [1:0]   pad;
  logic         relu;
  logic [4:0]   shift;
  logic [143:0] kernel;
  logic [10:0]  mi_addr;
  logic [31:0]  mi_data;
  logic         mi_wr;
  logic [8:0]   mo_addr;
  logic [31:0]  mo_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv2d_mc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .data_width(dw), .data_height(dh), .result_width(rw), .result_height(rh),
    .stride_x(sx), .stride_y(sy), .kernel_width(kw), .kernel_height(kh),
    .num_ch(nch), .pad(pad), .relu_en(relu), .shift(shift), .kernel(kernel),
    .mi_addr(mi_addr), .mi_data(mi_data), .mi_wr(mi_wr),
    .mo_addr(mo_addr), .mo_data(mo_data)
  );

  task automatic cfg(input int d, input int r, input int s, input int k, input int c,
                     input int p, input logic rl, input int sh);
    dw = 8'(d); dh = 8'(d); rw = 8'(r); rh = 8'(r);
    sx = 4'(s); sy = 4'(s); kw = 4'(k); kh = 4'(k);
    nch = 4'(c); pad = 2'(p); relu = rl; shift = 5'(sh);
  endtask

  task automatic set_w(input int c, input int ky, input int kx, input int val);
    kernel[8*(c*9+ky*3+kx) +: 8] = val[7:0];
  endtask

  // Rows {a, 0, -a}: a=1 gives -6 on the ramp, a=-1 gives +6
  task automatic kernel_rows(input int c, input int a);
    for (int ky = 0; ky < 3; ky++) begin
      set_w(c, ky, 0, a); set_w(c, ky, 1, 0); set_w(c, ky, 2, -a);
    end
  endtask

  task automatic kernel_fill(input int c, input int val);
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) set_w(c, ky, kx, val);
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    @(posedge clk); #1;
    mi_addr = 11'(a); mi_data = d; mi_wr = 1'b1;
    @(posedge clk); #1;
    mi_wr = 1'b0;
  endtask

  task automatic load_ramp();
    for (int w = 0; w < 16; w++)
      write_word(4*w, {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
  endtask

  task automatic load_fill(input int base, input int nwords, input logic [7:0] b);
    for (int w = 0; w < nwords; w++) write_word(base + 4*w, {4{b}});
  endtask

  task automatic read_word(input int a, output logic [31:0] d);
    @(posedge clk); #1;
    mo_addr = 9'(a);
    @(posedge clk); #1;
    d = mo_data;
  endtask

  // cycles counts posedges from the one that samples start to the one that raises done
  task automatic run_conv(output int cycles, output logic busy0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    cycles = 1;
    while (!done && cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; start = 1'b0; mi_wr = 1'b0; mi_addr = '0; mi_data = '0;
    mo_addr = 9'd0; kernel = '0;
    cfg(8, 6, 1, 3, 1, 0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (mo_data !== 32'd0) begin errors++; $display("FAIL reset_mo_data got=%h exp=0", mo_data); end
    rst_n = 1'b1;
    read_word(300, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mo_addr_oob got=%h exp=0", d); end
  endtask

  task automatic test_ramp();
    int cyc; logic b0; logic [31:0] d;
    load_ramp();
    kernel = '0; kernel_rows(0, 1);
    cfg(8, 6, 1, 3, 1, 0, 1'b0, 0);
    run_conv(cyc, b0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL ramp_busy got=%b exp=1", b0); end
    checks++; if (cyc !== 363) begin errors++; $display("FAIL ramp_latency got=%0d exp=363", cyc); end
    for (int i = 0; i < 36; i++) begin
      read_word(i, d);
      checks++; if (d !== 32'hFFFF_FFFA) begin errors++; $display("FAIL ramp_word%0d got=%h exp=fffffffa", i, d); end
    end
  endtask

  task automatic test_relu_shift();
    int cyc; logic b0; logic [31:0] d;
    cfg(8, 6, 1, 3, 1, 0, 1'b1, 0);
    run_conv(cyc, b0);
    checks++; if (cyc !== 363) begin errors++; $display("FAIL relu_latency got=%0d exp=363", cyc); end
    for (int i = 0; i < 36; i++) begin
      read_word(i, d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL relu_word%0d got=%h exp=0", i, d); end
    end
    kernel = '0; kernel_rows(0, -1);
    cfg(8, 6, 1, 3, 1, 0, 1'b0, 1);
    run_conv(cyc, b0);
    checks++; if (cyc !== 363) begin errors++; $display("FAIL shift_latency got=%0d exp=363", cyc); end
    for (int i = 0; i < 36; i++) begin
      read_word(i, d);
      checks++; if (d !== 32'd3) begin errors++; $display("FAIL shift_word%0d got=%h exp=3", i, d); end
    end
  endtask

  task automatic test_two_channels();
    int cyc; logic b0; logic [31:0] d;
    load_fill(64, 16, 8'h01);
    kernel = '0; kernel_rows(0, 1); kernel_fill(1, 1);
    cfg(8, 6, 1, 3, 2, 0, 1'b0, 0);
    run_conv(cyc, b0);
    checks++; if (cyc !== 687) begin errors++; $display("FAIL twoch_latency got=%0d exp=687", cyc); end
    for (int i = 0; i < 36; i++) begin
      read_word(i, d);
      checks++; if (d !== 32'd3) begin errors++; $display("FAIL twoch_word%0d got=%h exp=3", i, d); end
    end
  endtask

  task automatic test_stride();
    int cyc; logic b0; logic [31:0] d;
    kernel = '0; kernel_rows(0, 1);
    cfg(8, 3, 2, 3, 1, 0, 1'b0, 0);
    run_conv(cyc, b0);
    checks++; if (cyc !== 93) begin errors++; $display("FAIL stride_latency got=%0d exp=93", cyc); end
    for (int i = 0; i < 9; i++) begin
      read_word(i, d);
      checks++; if (d !== 32'hFFFF_FFFA) begin errors++; $display("FAIL stride_word%0d got=%h exp=fffffffa", i, d); end
    end
    read_word(9, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL stride_word9_kept got=%h exp=3", d); end
  endtask

  task automatic test_start_during_busy();
    int cyc; logic [31:0] d;
    kernel = '0; kernel_rows(0, 1);
    cfg(8, 6, 1, 3, 1, 0, 1'b0, 0);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1;
    while (!done && cyc < 5000) begin
      if (cyc == 50) begin
        kernel = '0; kernel_rows(0, -1); shift = 5'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++; if (cyc !== 363) begin errors++; $display("FAIL startbusy_latency got=%0d exp=363", cyc); end
    for (int i = 0; i < 36; i++) begin
      read_word(i, d);
      checks++; if (d !== 32'hFFFF_FFFA) begin errors++; $display("FAIL startbusy_word%0d got=%h exp=fffffffa", i, d); end
    end
  endtask

  task automatic test_mi_wr_busy();
    int cyc; logic b0; logic [31:0] d;
    kernel = '0; kernel_rows(0, 1);
    cfg(8, 6, 1, 3, 1, 0, 1'b0, 0);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1;
    while (!done && cyc < 5000) begin
      if (cyc == 30) begin
        mi_addr = 11'd0; mi_data = 32'hFFFF_FFFF; mi_wr = 1'b1;
      end else begin
        mi_wr = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mi_wr = 1'b0;
    run_conv(cyc, b0);
    checks++; if (cyc !== 363) begin errors++; $display("FAIL miwr_latency got=%0d exp=363", cyc); end
    for (int i = 0; i < 6; i++) begin
      read_word(i, d);
      checks++; if (d !== 32'hFFFF_FFFA) begin errors++; $display("FAIL miwr_word%0d got=%h exp=fffffffa", i, d); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc; logic b0; logic [31:0] d;
    kernel = '0; kernel_rows(0, -1);
    cfg(8, 6, 1, 3, 1, 0, 1'b0, 1);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (100) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
    rst_n = 1'b1;
    run_conv(cyc, b0);
    checks++; if (cyc !== 363) begin errors++; $display("FAIL midrst_latency got=%0d exp=363", cyc); end
    for (int i = 0; i < 36; i++) begin
      read_word(i, d);
      checks++; if (d !== 32'd3) begin errors++; $display("FAIL midrst_word%0d got=%h exp=3", i, d); end
    end
  endtask

  task automatic test_padding();
    int cyc; logic b0; logic [31:0] d; int rv, cv;
    load_fill(0, 16, 8'h01);
    kernel = '0; kernel_fill(0, 1);
    cfg(8, 8, 1, 3, 1, 1, 1'b0, 0);
    run_conv(cyc, b0);
    checks++; if (cyc !== 643) begin errors++; $display("FAIL pad_latency got=%0d exp=643", cyc); end
    for (int oy = 0; oy < 8; oy++) begin
      for (int ox = 0; ox < 8; ox++) begin
        rv = (oy == 0 || oy == 7) ? 2 : 3;
        cv = (ox == 0 || ox == 7) ? 2 : 3;
        read_word(oy*8 + ox, d);
        checks++;
        if (d !== 32'(rv*cv)) begin
          errors++; $display("FAIL pad_word%0d got=%h exp=%0d", oy*8+ox, d, rv*cv);
        end
      end
    end
  endtask

  task automatic test_num_ch0();
    int cyc; logic b0; logic [31:0] d;
    cfg(8, 8, 1, 3, 0, 1, 1'b0, 0);
    run_conv(cyc, b0);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL nch0_latency got=%0d exp=3", cyc); end
    read_word(0, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL nch0_word0 got=%h exp=4", d); end
    read_word(27, d);
    checks++; if (d !== 32'd9) begin errors++; $display("FAIL nch0_word27 got=%h exp=9", d); end
  endtask

  task automatic test_saturation();
    int cyc; logic b0; logic [31:0] d;
    load_fill(0, 5, 8'hFF);
    kernel = '0; kernel_fill(0, 127); kernel_fill(1, 127);
    cfg(3, 1, 1, 3, 2, 0, 1'b0, 0);
    run_conv(cyc, b0);
    checks++; if (cyc !== 22) begin errors++; $display("FAIL sat_latency got=%0d exp=22", cyc); end
    read_word(0, d);
    checks++; if (d !== 32'd32767) begin errors++; $display("FAIL sat_shift0 got=%h exp=00007fff", d); end
    read_word(1, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL sat_word1_kept got=%h exp=6", d); end
    shift = 5'd5;
    run_conv(cyc, b0);
    read_word(0, d);
    checks++; if (d !== 32'd18216) begin errors++; $display("FAIL sat_shift5 got=%0d exp=18216", d); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_relu_shift();
    test_two_channels();
    test_stride();
    test_start_during_busy();
    test_mi_wr_busy();
    test_reset_mid();
    test_padding();
    test_num_ch0();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
